tl_width_widget_arbiter: RTL
============================

// Module: tl_width_widget_arbiter
// PURPOSE
// - Two-client TileLink-UH arbiter placed in front of the 64-bit width-widget stage; it shares one manager-side A/D link between two client ports.
// - A channel: round-robin arbitration, held for all beats of a multi-beat burst; tags the grant winner in the source MSB.
// - D channel: each response goes back to the client named by its source MSB; the tag is stripped on the way back.
// - Zero-latency, combinational datapath; the only state is arbitration state.
// PARAMETERS
// - BEAT_BYTES  8  bytes per data beat (64-bit data); log2 = 3
// - MAX_SIZE    7  largest log2(transfer bytes) accepted; burst counter width = MAX_SIZE-3 = 4
// - SRC_BITS    7  client source width; manager source = SRC_BITS+1 = 8
// PORTS
// - clock                     in   1   single clock, all state on posedge
// - reset                     in   1   synchronous, active-high
// - auto_in_N_a_valid/ready   in/out  1   client N (N=0,1) A handshake
// - auto_in_N_a_bits_*        in   -   opcode3 param3 size3 source7 address31 mask8 data64 corrupt1
// - auto_in_N_d_valid/ready   out/in  1   client N D handshake
// - auto_in_N_d_bits_*        out  -   opcode3 param2 size3 source7 sink1 denied1 data64 corrupt1
// - auto_out_a_valid/ready    out/in  1   manager A handshake
// - auto_out_a_bits_*         out  -   opcode3 param3 size3 source8 address31 mask8 data64 corrupt1
// - auto_out_d_valid/ready    in/out  1   manager D handshake
// - auto_out_d_bits_*         in   -   opcode3 param2 size3 source8 sink1 denied1 data64 corrupt1
// BEHAVIOUR
// - State: rr_last (1b, last winner), locked (1b), lock_id (1b), beats_left (4b).
//   - Reset values: rr_last=1, so client 0 wins first; locked=0; beats_left=0.
// - Outputs while reset=1:
//   - auto_out_a_valid=0, auto_in_N_a_ready=0, auto_in_N_d_valid=0, auto_out_d_ready=0.
//   - Payloads are don't-care.
// - Grant when locked=0:
//   - Only one client valid: that client wins.
//   - Both valid: the winner is !rr_last.
//   - Grant is combinational in the same cycle, with no bubble.
// - Grant when locked=1: grant=lock_id; the other client sees ready=0 regardless of its valid.
// - A forwarding:
//   - auto_out_a_valid = valid of the granted client.
//   - auto_out_a_bits = granted payload, with source = {grant_id, in_source[6:0]}.
//   - auto_in_N_a_ready = auto_out_a_ready & (grant==N) & !reset.
// - Beat count:
//   - has_data = opcode in {0 PutFull, 1 PutPartial, 2 Arith, 3 Logic}.
//   - beats = (has_data && size>3) ? 1<<(size-3) : 1.
// - On an A fire with locked=0:
//   - rr_last <= grant.
//   - If beats>1: locked<=1, lock_id<=grant, beats_left<=beats-1.
// - On an A fire with locked=1:
//   - beats_left <= beats_left-1.
//   - When beats_left==1, locked<=0 in the same cycle; arbitration is free on the next cycle.
// - A valid without ready: grant may change only while locked=0. Valid-before-ready stability is the clients' obligation.
// - D routing:
//   - id = auto_out_d_bits_source[7].
//   - auto_in_id_d_valid = auto_out_d_valid; auto_in_!id_d_valid = 0.
//   - auto_out_d_ready = auto_in_id_d_ready.
//   - Client source = source[6:0]; the other D fields pass through unchanged.
//   - A and D are independent: D routing needs no state; multi-beat D uses the same source on every beat.
// - Simultaneous A last-beat and D fire: no interaction.
// - Reset asserted mid-burst: state returns to its reset values on the next edge. The partial burst is abandoned; clients must also be reset.
// - size>MAX_SIZE: the behaviour is undefined; an assertion fires in simulation only (`ifndef SYNTHESIS).
// STRUCTURE
// - Shared package tl_arb_pkg:
//   - TL opcode localparams.
//   - Beat-width constants (BEAT_BYTES, log2).
//   - A/D payload struct typedefs.
//   - function tl_num_beats(opcode,size).
// - One sub-module, tl_rr_lock_arbiter: holds rr_last/locked/beats_left and outputs grant_id.
// - The top level is muxing and source tagging only.
// TESTING
// - Reset, then both clients issue Get size=3 src=0x05 in the same cycle with out_a_ready=1:
//   - client 0 fires first with out source 0x05;
//   - client 1 fires next cycle with out source 0x85.
// - Client 1 PutFull size=6 (8 beats) alongside a continuous client 0 Get:
//   - 8 consecutive client-1 beats with in_0_a_ready=0 throughout;
//   - the client 0 Get fires on cycle 9.
// - Burst with out_a_ready toggling 1,0,1,0: lock holds and beats_left decrements only on fires; unlock after beat 4 of a size=5 Put.
// - D AccessAckData source=0x83, size=6, 8 beats, in_1_d_ready=1:
//   - in_1_d_valid=1 with source 0x03 on every beat;
//   - in_0_d_valid=0 throughout.
// - D source=0x02 while in_0_d_ready=0: auto_out_d_ready=0 and the beat is held; it completes when ready rises.
// - Reset pulse after beat 3 of an 8-beat Put:
//   - next cycle locked=0, rr_last=1;
//   - a fresh client 0 Get wins immediately.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UH definitions for the two-client arbiter in front of the 64-bit width widget.
package tl_arb_pkg;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_LOG2  = $clog2(BEAT_BYTES);
  localparam int MAX_SIZE   = 7;
  localparam int SRC_BITS   = 7;
  localparam int CNT_BITS   = MAX_SIZE - BEAT_LOG2;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_ARITH       = 3'd2;
  localparam logic [2:0] TL_LOGIC       = 3'd3;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [2:0]          size;
    logic [SRC_BITS-1:0] source;
    logic [30:0]         address;
    logic [7:0]          mask;
    logic [63:0]         data;
    logic                corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          param;
    logic [2:0]          size;
    logic [SRC_BITS-1:0] source;
    logic                sink;
    logic                denied;
    logic [63:0]         data;
    logic                corrupt;
  } tl_d_t;

  // Only the four data-carrying A opcodes span more than one beat.
  function automatic logic [CNT_BITS:0] tl_num_beats(input logic [2:0] opcode,
                                                     input logic [2:0] size);
    logic has_data;
    has_data = opcode inside {TL_PUT_FULL, TL_PUT_PARTIAL, TL_ARITH, TL_LOGIC};
    if (has_data && (size > 3'(BEAT_LOG2)))
      return (CNT_BITS+1)'(1) << (size - 3'(BEAT_LOG2));
    return (CNT_BITS+1)'(1);
  endfunction

endpackage

// File: rtl/tl_width_widget_arbiter_if.sv
// TileLink-UH A/D link bundle; SRC_W is 7 on client ports and 8 on the manager port.
interface tl_width_widget_arbiter_if #(parameter int SRC_W = 7);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [2:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [30:0]      a_address;
  logic [7:0]       a_mask;
  logic [63:0]      a_data;
  logic             a_corrupt;

  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [2:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_sink;
  logic             d_denied;
  logic [63:0]      d_data;
  logic             d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_rr_lock_arbiter.sv
// Two-way round-robin grant that stays pinned to one client for every beat of a multi-beat A message.
// state      | meaning
// ARB_FREE   | no burst in flight; grant follows valids, ties go to !rr_last
// ARB_LOCKED | burst in flight; grant pinned to lock_id until beats_left runs out
module tl_rr_lock_arbiter
  import tl_arb_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          valid_i,
  input  logic                fire_i,
  input  logic [CNT_BITS:0]   beats_i,
  output logic                grant_o
);

  arb_state_e          state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                lock_id_q, lock_id_d;
  logic [CNT_BITS-1:0] beats_left_q, beats_left_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_FREE;
      rr_last_q    <= 1'b1;
      lock_id_q    <= 1'b0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      lock_id_q    <= lock_id_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    lock_id_d    = lock_id_q;
    beats_left_d = beats_left_q;
    grant_o      = ~rr_last_q;
    case (state_q)
      ARB_FREE: begin
        if (valid_i[0] ^ valid_i[1]) grant_o = valid_i[1];
        if (fire_i) begin
          rr_last_d = grant_o;
          if (beats_i > (CNT_BITS+1)'(1)) begin
            state_d      = ARB_LOCKED;
            lock_id_d    = grant_o;
            beats_left_d = CNT_BITS'(beats_i - (CNT_BITS+1)'(1));
          end
        end
      end
      ARB_LOCKED: begin
        grant_o = lock_id_q;
        if (fire_i) begin
          beats_left_d = beats_left_q - CNT_BITS'(1);
          if (beats_left_q == CNT_BITS'(1)) state_d = ARB_FREE;
        end
      end
      default: state_d = ARB_FREE;
    endcase
  end

endmodule

// File: rtl/tl_width_widget_arbiter.sv
// Shares one manager-side TL-UH A/D link between two clients: A is arbitrated and tagged
// in the source MSB, D is routed back by that tag with the tag stripped.
module tl_width_widget_arbiter
  import tl_arb_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  tl_width_widget_arbiter_if.slave   auto_in_0,
  tl_width_widget_arbiter_if.slave   auto_in_1,
  tl_width_widget_arbiter_if.master  auto_out
);

  tl_a_t             a_in [2];
  tl_a_t             a_sel;
  tl_d_t             d_ret;
  logic              grant;
  logic              a_fire;
  logic              d_id;
  logic [CNT_BITS:0] a_beats;

  assign a_in[0] = '{opcode: auto_in_0.a_opcode, param: auto_in_0.a_param, size: auto_in_0.a_size,
                     source: auto_in_0.a_source, address: auto_in_0.a_address, mask: auto_in_0.a_mask,
                     data: auto_in_0.a_data, corrupt: auto_in_0.a_corrupt};
  assign a_in[1] = '{opcode: auto_in_1.a_opcode, param: auto_in_1.a_param, size: auto_in_1.a_size,
                     source: auto_in_1.a_source, address: auto_in_1.a_address, mask: auto_in_1.a_mask,
                     data: auto_in_1.a_data, corrupt: auto_in_1.a_corrupt};
  assign a_sel   = a_in[grant];
  assign a_beats = tl_num_beats(a_sel.opcode, a_sel.size);

  assign auto_out.a_valid   = (grant ? auto_in_1.a_valid : auto_in_0.a_valid) & ~reset;
  assign auto_out.a_opcode  = a_sel.opcode;
  assign auto_out.a_param   = a_sel.param;
  assign auto_out.a_size    = a_sel.size;
  assign auto_out.a_source  = {grant, a_sel.source};
  assign auto_out.a_address = a_sel.address;
  assign auto_out.a_mask    = a_sel.mask;
  assign auto_out.a_data    = a_sel.data;
  assign auto_out.a_corrupt = a_sel.corrupt;
  assign auto_in_0.a_ready  = auto_out.a_ready & ~grant & ~reset;
  assign auto_in_1.a_ready  = auto_out.a_ready & grant & ~reset;
  assign a_fire             = auto_out.a_valid & auto_out.a_ready;

  tl_rr_lock_arbiter u_arb (
    .clock   (clock),
    .reset   (reset),
    .valid_i ({auto_in_1.a_valid, auto_in_0.a_valid}),
    .fire_i  (a_fire),
    .beats_i (a_beats),
    .grant_o (grant)
  );

  // D routing is stateless: every beat carries the tag that picks its client.
  assign d_id  = auto_out.d_source[SRC_BITS];
  assign d_ret = '{opcode: auto_out.d_opcode, param: auto_out.d_param, size: auto_out.d_size,
                   source: auto_out.d_source[SRC_BITS-1:0], sink: auto_out.d_sink,
                   denied: auto_out.d_denied, data: auto_out.d_data, corrupt: auto_out.d_corrupt};

  assign auto_in_0.d_valid  = auto_out.d_valid & ~d_id & ~reset;
  assign auto_in_1.d_valid  = auto_out.d_valid & d_id & ~reset;
  assign auto_out.d_ready   = (d_id ? auto_in_1.d_ready : auto_in_0.d_ready) & ~reset;

  assign auto_in_0.d_opcode  = d_ret.opcode;
  assign auto_in_0.d_param   = d_ret.param;
  assign auto_in_0.d_size    = d_ret.size;
  assign auto_in_0.d_source  = d_ret.source;
  assign auto_in_0.d_sink    = d_ret.sink;
  assign auto_in_0.d_denied  = d_ret.denied;
  assign auto_in_0.d_data    = d_ret.data;
  assign auto_in_0.d_corrupt = d_ret.corrupt;
  assign auto_in_1.d_opcode  = d_ret.opcode;
  assign auto_in_1.d_param   = d_ret.param;
  assign auto_in_1.d_size    = d_ret.size;
  assign auto_in_1.d_source  = d_ret.source;
  assign auto_in_1.d_sink    = d_ret.sink;
  assign auto_in_1.d_denied  = d_ret.denied;
  assign auto_in_1.d_data    = d_ret.data;
  assign auto_in_1.d_corrupt = d_ret.corrupt;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && auto_out.a_valid)
      assert (int'(a_sel.size) <= MAX_SIZE) else $error("A size above MAX_SIZE");
  end
`endif

endmodule
